// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
// The slave side is the arbiter. The master side is the fetch/loader requesters plus the memory array.
interface imem_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              f_req;
   logic [31:0]       f_addr;
   logic              f_ready;
   logic              f_valid;
   logic [DATA_W-1:0] f_inst;

   logic              l_req;
   logic              l_we;
   logic [31:0]       l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_lock;
   logic              l_ready;
   logic              l_valid;
   logic [DATA_W-1:0] l_rdata;

   logic              locked;
   logic [15:0]       load_cnt;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  f_req, f_addr,
      output f_ready, f_valid, f_inst,
      input  l_req, l_we, l_addr, l_wdata, l_lock,
      output l_ready, l_valid, l_rdata,
      output locked, load_cnt,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output f_req, f_addr,
      input  f_ready, f_valid, f_inst,
      output l_req, l_we, l_addr, l_wdata, l_lock,
      input  l_ready, l_valid, l_rdata,
      input  locked, load_cnt,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin/lockable arbiter sharing one sync-read instruction memory between fetch and loader.
// Grant is same-cycle and combinational, and read data returns one cycle later; there is no backpressure on returned data.
module imem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   imem_arbiter_if.slave    bus
);

   typedef enum logic {SHARE = 1'b0, LOCKED = 1'b1} state_t;
   typedef enum logic {PORT_F = 1'b0, PORT_L = 1'b1} port_t;

   state_t            state;
   port_t             last_gnt;
   logic              rd_vld;
   port_t             rd_port;
   logic              rd_oor;
   logic [15:0]       load_cnt_q;

   logic              f_oor;
   logic              l_oor;
   logic              f_gnt;
   logic              l_gnt;
   logic              mem_en_c;
   logic              mem_we_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [DATA_W-1:0] mem_wdata_c;
   logic              unused_addr_lsbs;

   // Byte-lane bits are meaningless for a word-wide memory.
   assign unused_addr_lsbs = ^{bus.f_addr[1:0], bus.l_addr[1:0]};

   assign f_oor = |bus.f_addr[31:ADDR_W+2];
   assign l_oor = |bus.l_addr[31:ADDR_W+2];

   always_comb begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      if (rst_n) begin
         if (state == LOCKED) begin
            l_gnt = bus.l_req;
         end else if (bus.f_req && bus.l_req) begin
            f_gnt = (last_gnt == PORT_L);
            l_gnt = (last_gnt == PORT_F);
         end else begin
            f_gnt = bus.f_req;
            l_gnt = bus.l_req;
         end
      end
   end

   // Out-of-range accesses are acknowledged but never reach the array.
   always_comb begin
      mem_en_c    = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      if (f_gnt) begin
         mem_en_c   = !f_oor;
         mem_addr_c = bus.f_addr[ADDR_W+1:2];
      end else if (l_gnt) begin
         mem_en_c   = !l_oor;
         mem_we_c   = bus.l_we && !l_oor;
         mem_addr_c = bus.l_addr[ADDR_W+1:2];
         if (bus.l_we) begin
            mem_wdata_c = bus.l_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SHARE;
         last_gnt   <= PORT_L;
         rd_vld     <= 1'b0;
         rd_port    <= PORT_F;
         rd_oor     <= 1'b0;
         load_cnt_q <= 16'h0000;
      end else begin
         state <= bus.l_lock ? LOCKED : SHARE;

         if (f_gnt) begin
            last_gnt <= PORT_F;
         end else if (l_gnt) begin
            last_gnt <= PORT_L;
         end

         // Return tag for the access issued this cycle; writes produce no valid.
         rd_vld  <= f_gnt || (l_gnt && !bus.l_we);
         rd_port <= l_gnt ? PORT_L : PORT_F;
         rd_oor  <= f_gnt ? f_oor : l_oor;

         if (l_gnt && bus.l_we && !l_oor && (load_cnt_q != 16'hFFFF)) begin
            load_cnt_q <= load_cnt_q + 16'd1;
         end
      end
   end

   assign bus.f_ready   = f_gnt;
   assign bus.l_ready   = l_gnt;
   assign bus.mem_en    = mem_en_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_addr  = mem_addr_c;
   assign bus.mem_wdata = mem_wdata_c;

   assign bus.f_valid = rd_vld && (rd_port == PORT_F);
   assign bus.l_valid = rd_vld && (rd_port == PORT_L);
   assign bus.f_inst  = (bus.f_valid && !rd_oor) ? bus.mem_rdata : '0;
   assign bus.l_rdata = (bus.l_valid && !rd_oor) ? bus.mem_rdata : '0;

   assign bus.locked   = (state == LOCKED);
   assign bus.load_cnt = load_cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 1024x32 sync-read memory.
module tb_imem_arbiter;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst_n;
   logic mem_init_done = 1'b0;
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Preloaded image: word i holds 0xA000_0000 + i.
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < (1<<ADDR_W); i++) mem[i] <= 32'hA000_0000 + i;
         mem_init_done <= 1'b1;
      end else if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else bus.mem_rdata <= mem[bus.mem_addr];
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.f_req = 1'b0; bus.f_addr = 32'h0;
      bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = 32'h0;
      bus.l_wdata = 32'h0; bus.l_lock = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.f_req = 1'b1; bus.l_req = 1'b1; bus.f_addr = 32'h40; bus.l_addr = 32'h80;
      rst_n = 1'b0;
      #2;
      total++; if (bus.f_ready !== 1'b0) $display("FAIL rst_f_ready got %b exp 0", bus.f_ready); else passed++;
      total++; if (bus.l_ready !== 1'b0) $display("FAIL rst_l_ready got %b exp 0", bus.l_ready); else passed++;
      total++; if (bus.f_valid !== 1'b0) $display("FAIL rst_f_valid got %b exp 0", bus.f_valid); else passed++;
      total++; if (bus.l_valid !== 1'b0) $display("FAIL rst_l_valid got %b exp 0", bus.l_valid); else passed++;
      total++; if (bus.f_inst !== 32'h0) $display("FAIL rst_f_inst got %h exp 0", bus.f_inst); else passed++;
      total++; if (bus.l_rdata !== 32'h0) $display("FAIL rst_l_rdata got %h exp 0", bus.l_rdata); else passed++;
      total++; if (bus.mem_en !== 1'b0) $display("FAIL rst_mem_en got %b exp 0", bus.mem_en); else passed++;
      total++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we got %b exp 0", bus.mem_we); else passed++;
      total++; if (bus.mem_addr !== 10'h0) $display("FAIL rst_mem_addr got %h exp 0", bus.mem_addr); else passed++;
      total++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got %h exp 0", bus.mem_wdata); else passed++;
      total++; if (bus.locked !== 1'b0) $display("FAIL rst_locked got %b exp 0", bus.locked); else passed++;
      total++; if (bus.load_cnt !== 16'h0) $display("FAIL rst_load_cnt got %h exp 0", bus.load_cnt); else passed++;
      repeat (3) next_cycle();
      idle_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_seq_fetch();
      next_cycle();
      bus.f_req = 1'b1; bus.f_addr = 32'h0;
      #1;
      total++; if (bus.f_ready !== 1'b1) $display("FAIL seq_ready0 got %b exp 1", bus.f_ready); else passed++;
      total++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'd0) $display("FAIL seq_mem0 got en=%b addr=%0d exp en=1 addr=0", bus.mem_en, bus.mem_addr); else passed++;
      total++; if (bus.f_valid !== 1'b0) $display("FAIL seq_valid0 got %b exp 0", bus.f_valid); else passed++;
      for (int i = 1; i <= 3; i++) begin
         next_cycle();
         if (i < 3) bus.f_addr = 32'(4 * i);
         else bus.f_req = 1'b0;
         #1;
         if (i < 3) begin
            total++; if (bus.f_ready !== 1'b1 || bus.mem_addr !== 10'(i)) $display("FAIL seq_grant%0d got rdy=%b addr=%0d exp rdy=1 addr=%0d", i, bus.f_ready, bus.mem_addr, i); else passed++;
         end
         total++; if (bus.f_valid !== 1'b1 || bus.f_inst !== 32'hA000_0000 + 32'(i-1)) $display("FAIL seq_data%0d got v=%b inst=%h exp v=1 inst=%h", i, bus.f_valid, bus.f_inst, 32'hA000_0000 + 32'(i-1)); else passed++;
      end
      next_cycle();
      #1;
      total++; if (bus.f_valid !== 1'b0) $display("FAIL seq_valid_end got %b exp 0", bus.f_valid); else passed++;
   endtask

   task automatic test_write_then_fetch();
      next_cycle();
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h10; bus.l_wdata = 32'hDEAD_BEEF;
      #1;
      total++; if (bus.l_ready !== 1'b1 || bus.mem_we !== 1'b1) $display("FAIL wr_grant got rdy=%b we=%b exp 1/1", bus.l_ready, bus.mem_we); else passed++;
      total++; if (bus.mem_addr !== 10'd4 || bus.mem_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_bus got addr=%0d data=%h exp 4/deadbeef", bus.mem_addr, bus.mem_wdata); else passed++;
      next_cycle();
      bus.l_req = 1'b0; bus.l_we = 1'b0; bus.f_req = 1'b1; bus.f_addr = 32'h10;
      #1;
      total++; if (bus.f_ready !== 1'b1) $display("FAIL wrf_ready got %b exp 1", bus.f_ready); else passed++;
      total++; if (bus.l_valid !== 1'b0) $display("FAIL wr_no_valid got %b exp 0", bus.l_valid); else passed++;
      total++; if (bus.load_cnt !== 16'd1) $display("FAIL wr_load_cnt got %0d exp 1", bus.load_cnt); else passed++;
      next_cycle();
      bus.f_req = 1'b0;
      #1;
      total++; if (bus.f_valid !== 1'b1 || bus.f_inst !== 32'hDEAD_BEEF) $display("FAIL wrf_data got v=%b inst=%h exp v=1 inst=deadbeef", bus.f_valid, bus.f_inst); else passed++;
   endtask

   task automatic test_round_robin();
      logic exp_f, exp_l, exp_fv;
      do_reset();
      for (int i = 0; i <= 6; i++) begin
         next_cycle();
         if (i < 6) begin
            bus.f_req = 1'b1; bus.l_req = 1'b1; bus.f_addr = 32'h20; bus.l_addr = 32'h44;
         end else begin
            bus.f_req = 1'b0; bus.l_req = 1'b0;
         end
         #1;
         exp_f = (i < 6) && (i % 2 == 0);
         exp_l = (i < 6) && (i % 2 == 1);
         total++; if (bus.f_ready !== exp_f || bus.l_ready !== exp_l) $display("FAIL rr_grant%0d got f=%b l=%b exp f=%b l=%b", i, bus.f_ready, bus.l_ready, exp_f, exp_l); else passed++;
         if (i > 0) begin
            exp_fv = ((i - 1) % 2 == 0);
            total++; if (bus.f_valid !== exp_fv || bus.l_valid !== !exp_fv) $display("FAIL rr_valid%0d got f=%b l=%b exp f=%b l=%b", i, bus.f_valid, bus.l_valid, exp_fv, !exp_fv); else passed++;
            if (exp_fv) begin
               total++; if (bus.f_inst !== 32'hA000_0008) $display("FAIL rr_finst%0d got %h exp a0000008", i, bus.f_inst); else passed++;
            end else begin
               total++; if (bus.l_rdata !== 32'hA000_0011) $display("FAIL rr_lrdata%0d got %h exp a0000011", i, bus.l_rdata); else passed++;
            end
         end
      end
   endtask

   task automatic test_lock();
      next_cycle();
      bus.f_req = 1'b1; bus.l_req = 1'b1; bus.l_lock = 1'b1; bus.f_addr = 32'h0C; bus.l_addr = 32'h14;
      #1;
      total++; if (bus.locked !== 1'b0 || bus.f_ready !== 1'b1 || bus.l_ready !== 1'b0) $display("FAIL lock_edge got lk=%b f=%b l=%b exp 0/1/0", bus.locked, bus.f_ready, bus.l_ready); else passed++;
      for (int j = 0; j < 3; j++) begin
         next_cycle();
         if (j == 2) bus.l_lock = 1'b0;
         #1;
         total++; if (bus.locked !== 1'b1 || bus.f_ready !== 1'b0 || bus.l_ready !== 1'b1) $display("FAIL lock_hold%0d got lk=%b f=%b l=%b exp 1/0/1", j, bus.locked, bus.f_ready, bus.l_ready); else passed++;
         if (j == 0) begin
            total++; if (bus.f_valid !== 1'b1 || bus.f_inst !== 32'hA000_0003) $display("FAIL lock_last_share got v=%b inst=%h exp v=1 inst=a0000003", bus.f_valid, bus.f_inst); else passed++;
         end else begin
            total++; if (bus.l_valid !== 1'b1 || bus.l_rdata !== 32'hA000_0005) $display("FAIL lock_lrd%0d got v=%b data=%h exp v=1 data=a0000005", j, bus.l_valid, bus.l_rdata); else passed++;
         end
      end
      next_cycle();
      #1;
      total++; if (bus.locked !== 1'b0 || bus.f_ready !== 1'b1 || bus.l_ready !== 1'b0) $display("FAIL unlock_f got lk=%b f=%b l=%b exp 0/1/0", bus.locked, bus.f_ready, bus.l_ready); else passed++;
      next_cycle();
      #1;
      total++; if (bus.f_ready !== 1'b0 || bus.l_ready !== 1'b1) $display("FAIL unlock_l got f=%b l=%b exp 0/1", bus.f_ready, bus.l_ready); else passed++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_out_of_range();
      next_cycle();
      bus.f_req = 1'b1; bus.f_addr = 32'h0000_1000;
      #1;
      total++; if (bus.f_ready !== 1'b1 || bus.mem_en !== 1'b0) $display("FAIL oor_f_grant got rdy=%b en=%b exp 1/0", bus.f_ready, bus.mem_en); else passed++;
      next_cycle();
      bus.f_req = 1'b0;
      #1;
      total++; if (bus.f_valid !== 1'b1 || bus.f_inst !== 32'h0) $display("FAIL oor_f_data got v=%b inst=%h exp v=1 inst=0", bus.f_valid, bus.f_inst); else passed++;
      next_cycle();
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h8000_0000; bus.l_wdata = 32'h1234_5678;
      #1;
      total++; if (bus.l_ready !== 1'b1 || bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) $display("FAIL oor_wr got rdy=%b en=%b we=%b exp 1/0/0", bus.l_ready, bus.mem_en, bus.mem_we); else passed++;
      next_cycle();
      bus.l_we = 1'b0;
      #1;
      total++; if (bus.load_cnt !== 16'd0) $display("FAIL oor_load_cnt got %0d exp 0", bus.load_cnt); else passed++;
      total++; if (bus.l_ready !== 1'b1 || bus.mem_en !== 1'b0) $display("FAIL oor_rd got rdy=%b en=%b exp 1/0", bus.l_ready, bus.mem_en); else passed++;
      next_cycle();
      bus.l_req = 1'b0;
      #1;
      total++; if (bus.l_valid !== 1'b1 || bus.l_rdata !== 32'h0) $display("FAIL oor_l_data got v=%b data=%h exp v=1 data=0", bus.l_valid, bus.l_rdata); else passed++;
      total++; if (mem[0] !== 32'hA000_0000) $display("FAIL oor_mem_intact got %h exp a0000000", mem[0]); else passed++;
   endtask

   task automatic test_reset_mid_read();
      next_cycle();
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h30; bus.l_wdata = 32'h55;
      next_cycle();
      idle_inputs();
      bus.f_req = 1'b1; bus.f_addr = 32'h4;
      #1;
      total++; if (bus.f_ready !== 1'b1 || bus.load_cnt !== 16'd1) $display("FAIL mid_pre got rdy=%b cnt=%0d exp 1/1", bus.f_ready, bus.load_cnt); else passed++;
      next_cycle();
      bus.f_req = 1'b0;
      rst_n = 1'b0;
      #1;
      total++; if (bus.f_valid !== 1'b0 || bus.f_inst !== 32'h0) $display("FAIL mid_valid got v=%b inst=%h exp 0/0", bus.f_valid, bus.f_inst); else passed++;
      total++; if (bus.load_cnt !== 16'd0 || bus.locked !== 1'b0 || bus.mem_en !== 1'b0) $display("FAIL mid_state got cnt=%0d lk=%b en=%b exp 0/0/0", bus.load_cnt, bus.locked, bus.mem_en); else passed++;
      next_cycle();
      rst_n = 1'b1;
      #1;
      total++; if (bus.f_valid !== 1'b0) $display("FAIL mid_hold got %b exp 0", bus.f_valid); else passed++;
      next_cycle();
      total++; if (bus.f_valid !== 1'b0) $display("FAIL mid_post got %b exp 0", bus.f_valid); else passed++;
      bus.f_req = 1'b1; bus.l_req = 1'b1; bus.f_addr = 32'h0; bus.l_addr = 32'h0;
      #1;
      total++; if (bus.f_ready !== 1'b1 || bus.l_ready !== 1'b0) $display("FAIL mid_first_tie got f=%b l=%b exp 1/0", bus.f_ready, bus.l_ready); else passed++;
      next_cycle();
      idle_inputs();
      #1;
      total++; if (bus.f_valid !== 1'b1 || bus.f_inst !== 32'hA000_0000) $display("FAIL mid_first_data got v=%b inst=%h exp v=1 inst=a0000000", bus.f_valid, bus.f_inst); else passed++;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_seq_fetch();
      test_write_then_fetch();
      test_round_robin();
      test_lock();
      test_out_of_range();
      test_reset_mid_read();
      repeat (2) next_cycle();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter and sequencer in front of the single-port, word-addressed instruction memory (1024 × 32, synchronous read). It shares the memory between the CPU fetch stage and the program loader. The loader writes program images and reads them back for checking. Round-robin arbitration applies in normal operation; a lock mode gives the loader exclusive access during bulk programming. The block sits between the PC/fetch logic and the memory array.

## Interface
- ADDR_W, 10, word-address width into the memory (depth 2^ADDR_W)
- DATA_W, 32, instruction/data width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch read request
- f_addr  in  32  fetch byte address (PC)
- f_ready  out  1  fetch request accepted this cycle
- f_valid  out  1  fetch read data valid
- f_inst  out  DATA_W  fetched instruction
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  32  loader byte address
- l_wdata  in  DATA_W  loader write data
- l_lock  in  1  loader exclusive-access request
- l_ready  out  1  loader request accepted this cycle
- l_valid  out  1  loader read data valid
- l_rdata  out  DATA_W  loader read data
- locked  out  1  block is in LOCKED state
- load_cnt  out  16  number of loader writes completed (saturating)
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_we=0

## Operation
- Word address is addr[ADDR_W+1:2]. addr[1:0] is ignored.
- Out-of-range access: any of addr[31:ADDR_W+2] is nonzero.
  - Such a request is still accepted (ready=1) but does not assert mem_en.
  - A read returns 32'h0000_0000 (NOP) with valid on the normal schedule.
  - A write is dropped and does not increment load_cnt.
- States: SHARE (reset) and LOCKED.
  - SHARE→LOCKED when l_lock=1 is sampled at a rising edge.
  - LOCKED→SHARE when l_lock=0 is sampled.
  - The state affects arbitration from the cycle after the transition edge.
- SHARE arbitration:
  - A single requester is granted.
  - If both request, the grant goes to the port that was not granted most recently. The last-grant pointer resets to "loader", so fetch wins the first tie.
  - The pointer updates only on an accepted request.
- LOCKED arbitration: f_ready=0 regardless of f_req; the loader is granted whenever l_req=1.
- f_ready/l_ready are combinational from req, state and pointer. At most one ready is high per cycle. Grant implies acceptance in that same cycle.
- mem_en/mem_we/mem_addr/mem_wdata are combinational from the granted request. mem_en=0 and mem_we=0 when nothing is granted or the access is out of range.
- Read return:
  - A registered tag (port, oor) selects the destination in cycle N+1.
  - f_inst/l_rdata = mem_rdata when the matching valid is 1, 0 for an out-of-range access, and 0 otherwise.
- load_cnt increments on every accepted in-range write and saturates at 16'hFFFF.
- locked = (state == LOCKED).

## Timing
- Reset (rst_n low, async):
  - state=SHARE, pointer=loader, load_cnt=0.
  - f_valid=l_valid=0, f_inst=l_rdata=0.
  - f_ready=l_ready=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0.
  - locked=0.
- Reset mid-read drops the pending valid; no valid appears after deassertion.
- Read latency: request accepted at edge N, so valid is high for exactly one cycle in cycle N+1 (after edge N). No backpressure: the requester must capture data in that cycle.
- Write: takes effect at the acceptance edge. A read of the same word granted the next cycle returns the new data.
- Back-to-back: one access per cycle, fully pipelined. f_valid and l_valid are never both 1.
- Simultaneous l_lock rise and a fetch tie in SHARE: normal round-robin that cycle; fetch blocked from the next cycle.
- A read issued in the last SHARE cycle still returns its valid in the first LOCKED cycle.

## Test plan
- Reset, then f_req=1 with f_addr=0x0, 0x4, 0x8 on consecutive cycles:
  - f_ready=1 each cycle; mem_addr=0,1,2.
  - f_valid high in cycles 2–4; f_inst = preloaded words.
- Loader write then fetch: l_we=1, l_addr=0x10, l_wdata=0xDEADBEEF, followed next cycle by f_addr=0x10:
  - f_inst=0xDEADBEEF one cycle after the fetch is granted; load_cnt=1.
- Both requesting continuously for 6 cycles in SHARE:
  - grants alternate F,L,F,L,F,L starting with fetch.
  - f_valid/l_valid alternate with one-cycle lag.
- l_lock=1 while f_req=1 and l_req=1:
  - after one cycle locked=1, f_ready=0, l_ready=1 every cycle.
  - clearing l_lock restores round-robin the cycle after it is sampled low.
- Out-of-range access:
  - f_addr=0x0000_1000 (ADDR_W=10): mem_en=0, f_valid=1 next cycle, f_inst=0.
  - l_we=1 at 0x8000_0000: load_cnt unchanged, memory unchanged.
- Assert rst_n=0 in the cycle after a read is granted:
  - f_valid stays 0, all outputs at reset values, load_cnt=0.
  - the first request after release wins by fetch priority.
